// File: rtl/seven_seg_reader.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the BCD frame it shows.
// Samples are synchronised, deglitched, decoded into staging slots, then published per full sweep.
module seven_seg_reader #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           seg_n,
   input  logic [NDIG-1:0]      dig_n,
   output logic [4*NDIG-1:0]    bcd_out,
   output logic                 frame_stb,
   output logic                 frame_valid,
   output logic                 err_stb
);
   localparam int W  = NDIG + 7;
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYC);
   localparam logic [CW-1:0]   CNT_PRE = CW'(STABLE_CYC - 1);
   localparam logic [NDIG-1:0] LSB_ONE = NDIG'(1);

   logic [W-1:0]      sync1_reg, sync2_reg, prev_reg;
   logic [CW-1:0]     cnt_reg;
   logic [NDIG-1:0]   seen_reg;
   logic [4*NDIG-1:0] stage_reg, bcd_reg;
   logic              frame_stb_reg, frame_valid_reg, err_stb_reg;

   logic              same, accept, single, dark, complete, bad;
   logic [NDIG-1:0]   sel, seen_next;
   logic [3:0]        code;
   logic [4*NDIG-1:0] stage_next;

   function automatic logic [3:0] decode(input logic [6:0] p);
      case (p)
         7'b0000001: decode = 4'h0;
         7'b1001111: decode = 4'h1;
         7'b0010010: decode = 4'h2;
         7'b0000110: decode = 4'h3;
         7'b1001100: decode = 4'h4;
         7'b0100100: decode = 4'h5;
         7'b0100000: decode = 4'h6;
         7'b0001111: decode = 4'h7;
         7'b0000000: decode = 4'h8;
         7'b0000100: decode = 4'h9;
         7'b1111111: decode = 4'hF;
         default:    decode = 4'hE;
      endcase
   endfunction

   // A sample is taken only on the single cycle the counter reaches saturation.
   assign same   = (sync2_reg == prev_reg);
   assign accept = same && (cnt_reg == CNT_PRE);
   assign sel    = ~sync2_reg[W-1:7];
   assign dark   = (sel == '0);
   assign single = !dark && ((sel & (sel - LSB_ONE)) == '0);
   assign code   = decode(sync2_reg[6:0]);

   always_comb begin
      stage_next = stage_reg;
      for (int i = 0; i < NDIG; i++) begin
         if (sel[i]) stage_next[4*i +: 4] = code;
      end
      seen_next = seen_reg | sel;
      complete  = accept && single && (&seen_next);
      bad       = accept && ((single && code == 4'hE) || (!single && !dark));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg       <= '1;
         sync2_reg       <= '1;
         prev_reg        <= '1;
         cnt_reg         <= '0;
         seen_reg        <= '0;
         stage_reg       <= '1;
         bcd_reg         <= '1;
         frame_stb_reg   <= 1'b0;
         frame_valid_reg <= 1'b0;
         err_stb_reg     <= 1'b0;
      end else begin
         sync1_reg <= {dig_n, seg_n};
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         if (!same)
            cnt_reg <= '0;
         else if (cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + 1'b1;

         if (accept && single) begin
            stage_reg <= stage_next;
            seen_reg  <= complete ? '0 : seen_next;
         end
         if (complete) begin
            bcd_reg         <= stage_next;
            frame_valid_reg <= 1'b1;
         end
         frame_stb_reg <= complete;
         err_stb_reg   <= bad;
      end
   end

   assign bcd_out     = bcd_reg;
   assign frame_stb   = frame_stb_reg;
   assign frame_valid = frame_valid_reg;
   assign err_stb     = err_stb_reg;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: table of decode vectors plus hand-written corner sequences.
module tb_seven_seg_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_n = 7'h7F;
   logic [3:0]  dig_n = 4'hF;
   logic [15:0] bcd_out;
   logic        frame_stb, frame_valid, err_stb;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stb_cnt = 0;
   int err_cnt = 0;
   int stb_cyc = -1;
   int drive_cyc = 0;

   seven_seg_reader #(.NDIG(4), .STABLE_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
      .bcd_out(bcd_out), .frame_stb(frame_stb), .frame_valid(frame_valid), .err_stb(err_stb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_stb) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
         end
         if (err_stb) err_cnt = err_cnt + 1;
      end
   end

   typedef struct {
      logic [6:0] seg;
      logic [3:0] code;
      int         err;
   } vec_t;
   vec_t vecs[14];

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: pat = 7'b0000001;  1: pat = 7'b1001111;  2: pat = 7'b0010010;
         3: pat = 7'b0000110;  4: pat = 7'b1001100;  5: pat = 7'b0100100;
         6: pat = 7'b0100000;  7: pat = 7'b0001111;  8: pat = 7'b0000000;
         9: pat = 7'b0000100;  default: pat = 7'b1111111;
      endcase
   endfunction

   function automatic logic [3:0] pos_sel(input int p);
      logic [3:0] d;
      d = 4'hF;
      d[p] = 1'b0;
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
      @(negedge clk);
      dig_n = d;
      seg_n = s;
      drive_cyc = cyc;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clr();
      stb_cnt = 0;
      err_cnt = 0;
      stb_cyc = -1;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] exp;
      int p;

      vecs[0]  = '{pat(0), 4'h0, 0};  vecs[1]  = '{pat(1), 4'h1, 0};
      vecs[2]  = '{pat(2), 4'h2, 0};  vecs[3]  = '{pat(3), 4'h3, 0};
      vecs[4]  = '{pat(4), 4'h4, 0};  vecs[5]  = '{pat(5), 4'h5, 0};
      vecs[6]  = '{pat(6), 4'h6, 0};  vecs[7]  = '{pat(7), 4'h7, 0};
      vecs[8]  = '{pat(8), 4'h8, 0};  vecs[9]  = '{pat(9), 4'h9, 0};
      vecs[10] = '{7'b1111111, 4'hF, 0};
      vecs[11] = '{7'b1111110, 4'hE, 1};
      vecs[12] = '{7'b0110000, 4'hE, 1};
      vecs[13] = '{7'b1000000, 4'hE, 1};

      // reset state while held in reset
      repeat (3) @(negedge clk);
      chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
      chk("rst_valid", 32'(frame_valid), 0);
      chk("rst_stb", 32'(frame_stb), 0);
      chk("rst_err", 32'(err_stb), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // normal frame 1/2/3/4 with latency measurement
      clr();
      hold(4'b1110, pat(1), 10);
      hold(4'b1101, pat(2), 10);
      hold(4'b1011, pat(3), 10);
      hold(4'b0111, pat(4), 10);
      chk("norm_bcd", 32'(bcd_out), 32'h4321);
      chk("norm_stb_cnt", 32'(stb_cnt), 1);
      chk("norm_latency", 32'(stb_cyc - drive_cyc), 7);
      chk("norm_valid", 32'(frame_valid), 1);
      chk("norm_err_cnt", 32'(err_cnt), 0);

      // asynchronous reset takes effect without a clock edge
      hold(4'hF, 7'h7F, 10);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bcd", 32'(bcd_out), 32'hFFFF);
      chk("arst_valid", 32'(frame_valid), 0);
      chk("arst_stb", 32'(frame_stb), 0);
      chk("arst_err", 32'(err_stb), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // table of decode vectors, one frame per entry
      for (int k = 0; k < 14; k++) begin
         p = k % 4;
         exp = 16'h8888;
         exp[4*p +: 4] = vecs[k].code;
         clr();
         for (int q = 0; q < 4; q++)
            hold(pos_sel(q), (q == p) ? vecs[k].seg : pat(8), 10);
         chk($sformatf("vec%0d_bcd", k), 32'(bcd_out), 32'(exp));
         chk($sformatf("vec%0d_stb", k), 32'(stb_cnt), 1);
         chk($sformatf("vec%0d_err", k), 32'(err_cnt), 32'(vecs[k].err));
      end

      // deglitch: a 3-cycle glitch is never accepted
      clr();
      hold(4'b1110, pat(5), 10);
      hold(4'b1101, pat(6), 10);
      hold(4'b1011, pat(7), 10);
      hold(4'b0111, pat(9), 3);
      hold(4'hF, 7'h7F, 10);
      chk("glitch_stb", 32'(stb_cnt), 0);
      chk("glitch_err", 32'(err_cnt), 0);
      hold(4'b0111, pat(9), 30);
      chk("deglitch_stb", 32'(stb_cnt), 1);
      chk("deglitch_bcd", 32'(bcd_out), 32'h9765);

      // invalid pattern on position 2
      clr();
      hold(4'b1110, pat(0), 10);
      hold(4'b1101, pat(0), 10);
      hold(4'b1011, 7'b1111110, 10);
      hold(4'b0111, pat(0), 10);
      chk("inv_bcd", 32'(bcd_out), 32'h0E00);
      chk("inv_err", 32'(err_cnt), 1);
      chk("inv_stb", 32'(stb_cnt), 1);

      // multi-digit select leaves seen untouched
      clr();
      hold(4'b1011, pat(7), 10);
      hold(4'b0111, pat(8), 10);
      hold(4'b1100, pat(3), 10);
      hold(4'b1011, pat(6), 10);
      chk("multi_err", 32'(err_cnt), 1);
      chk("multi_stb", 32'(stb_cnt), 0);
      chk("multi_bcd_hold", 32'(bcd_out), 32'h0E00);
      hold(4'b1110, pat(1), 10);
      hold(4'b1101, pat(2), 10);
      chk("multi_sweep_stb", 32'(stb_cnt), 1);
      chk("multi_sweep_bcd", 32'(bcd_out), 32'h8621);
      chk("multi_sweep_err", 32'(err_cnt), 1);

      // reset mid-frame discards the partial frame
      clr();
      hold(4'b1110, pat(3), 10);
      hold(4'b1101, pat(4), 10);
      hold(4'hF, 7'h7F, 10);
      async_reset();
      hold(4'b1011, pat(5), 10);
      hold(4'b0111, pat(6), 10);
      chk("mid_rst_stb", 32'(stb_cnt), 0);
      chk("mid_rst_bcd", 32'(bcd_out), 32'hFFFF);
      chk("mid_rst_valid", 32'(frame_valid), 0);
      hold(4'b1110, pat(7), 10);
      hold(4'b1101, pat(8), 10);
      chk("mid_rst_done_stb", 32'(stb_cnt), 1);
      chk("mid_rst_done_bcd", 32'(bcd_out), 32'h6587);
      chk("mid_rst_done_valid", 32'(frame_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Receive side of the segment-display interface: snoops a multiplexed, active-low 7-segment display bus and reconstructs the BCD digits it shows.
- Uses the team's segment encoding: seg_n[6] = a … seg_n[0] = g, 0 = lit.
- Sits between the display-bus pins and the capture logic.
- Synchronises and deglitches the bus, decodes each stable digit into a staging slot, and publishes a complete frame once every digit position has been seen.

Parameters:
- NDIG, 4, number of multiplexed digit positions (≥2).
- STABLE_CYC, 4, consecutive unchanged synchronised cycles required before a sample is accepted (≥1).

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low, a..g = [6:0], asynchronous to clk.
- dig_n  input  NDIG  digit enables, active-low, one-hot-low when valid, asynchronous to clk.
- bcd_out  output  4*NDIG  last complete frame; slot i = bits [4i+3:4i].
- frame_stb  output  1  one-cycle pulse when bcd_out updates.
- frame_valid  output  1  high once at least one frame has been published.
- err_stb  output  1  one-cycle pulse on each accepted sample that is bad.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Synchroniser flops and the previous-sample register go to all ones.
  - Stability counter and seen[NDIG-1:0] go to 0.
  - Staging slots and bcd_out go to all 4'hF.
  - frame_stb, frame_valid and err_stb go to 0.
- Synchronisation: {dig_n, seg_n} passes through a 2-flop synchroniser; s = second-stage value.
- Stability counter cnt, width clog2(STABLE_CYC+1):
  - s ≠ previous s → cnt = 0.
  - Otherwise cnt increments, saturating at STABLE_CYC.
- accept pulses for exactly one cycle when cnt goes from STABLE_CYC-1 to STABLE_CYC.
  - One accept per stable period.
  - Minimum latency: pin change → accept = 2 + STABLE_CYC cycles.
- Decode on accept, segment pattern (abcdefg) → code:
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 1001100 → 4
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9
  - 1111111 → F (blank)
  - any other pattern → E (invalid)
- Accept handling by dig_n value:
  - Exactly one bit low (index i): write the code into staging slot i and set seen[i]. If the code is E, also pulse err_stb next cycle.
  - All ones (display dark): ignore, no error.
  - Two or more bits low: pulse err_stb next cycle; no slot write; seen unchanged.
- Repeat position before frame completion: the slot is overwritten and no error is raised.
- Frame completion: when an accept makes (seen | new bit) all ones, on that same edge:
  - bcd_out loads the staging contents including the new code.
  - seen clears to 0.
  - frame_stb = 1 for the following cycle; frame_valid = 1 and stays high until reset.
- bcd_out holds between frames; staging slots are not cleared at completion.
- Digit scan order is irrelevant; only set coverage matters.
- Reset mid-frame discards a partial frame; a full NDIG-position sweep is required afterwards.

Test Plan:
- Reset check: assert rst_n=0 mid-clock → bcd_out=16'hFFFF, frame_valid=0, frame_stb=0, err_stb=0 immediately, with no clock edge required.
- Normal frame (NDIG=4, STABLE_CYC=4): drive dig_n=1110/1101/1011/0111 with patterns for 1/2/3/4, each held 10 cycles → bcd_out=16'h4321, a single frame_stb pulse 7 cycles after the 4th digit appears, frame_valid=1, err_stb never high.
- Deglitch: hold a new pattern for only 3 clk cycles, then revert → no accept and no slot change. Hold it for 10 cycles → accepted exactly once.
- Invalid pattern: complete a frame with 7'b1111110 on dig_n=1011 and 0/0/0 on the other positions → bcd_out=16'h0E00, one err_stb pulse.
- Multi-digit select: dig_n=1100 held 10 cycles → one err_stb pulse, no frame_stb, seen unchanged. Subsequent clean sweep → frame published normally.
- Reset mid-frame: accept positions 0 and 1, pulse rst_n, then accept only positions 2 and 3 → no frame_stb and bcd_out stays 16'hFFFF. Adding positions 0 and 1 → frame_stb.
